// File: rtl/clint_axi_slave.sv
// clint_axi_slave: AXI-lite responder for the free-running 64-bit mtime timer, served as 32-bit halves.
// A low-word read snapshots the high word so that a following high-word read is coherent.
module clint_axi_slave #(
   parameter logic [31:0] RTC_ADDR      = 32'ha000_0048,
   parameter logic [31:0] RTC_ADDR_HIGH = 32'ha000_004c,
   parameter int unsigned TICK_DIV      = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic        high,
   output logic        rvalid,
   input  logic        rready,
   output logic [1:0]  rresp,
   output logic [63:0] rdata,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic        wvalid,
   output logic        wready,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp
);
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   typedef enum logic {R_IDLE, R_RESP} r_state_e;

   r_state_e      r_state_q, r_state_d;
   logic [63:0]   mtime_q, mtime_d, rdata_q, rdata_d, wdata_q, wdata_d, wr_data;
   logic [PW-1:0] presc_q, presc_d;
   logic [31:0]   hi_shadow_q, hi_shadow_d, awaddr_q, awaddr_d, wr_addr;
   logic [7:0]    wstrb_q, wstrb_d, wr_strb;
   logic [1:0]    rresp_q, rresp_d, bresp_q, bresp_d;
   logic          aw_got_q, aw_got_d, w_got_q, w_got_d, bvalid_q, bvalid_d;
   logic          rd_lo, rd_hi, aw_hs, w_hs, wr_go, wr_lo, wr_hi;

   assign arready = r_state_q == R_IDLE;
   assign rvalid  = r_state_q == R_RESP;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign awready = !aw_got_q;
   assign wready  = !w_got_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;

   always_comb begin
      r_state_d   = r_state_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      hi_shadow_d = hi_shadow_q;
      rd_lo       = araddr == RTC_ADDR && !high;
      rd_hi       = araddr == RTC_ADDR_HIGH && high;
      if (arvalid && arready) begin
         r_state_d   = R_RESP;
         rdata_d     = rd_lo ? {2{mtime_q[31:0]}} : rd_hi ? {2{hi_shadow_q}} : 64'd0;
         rresp_d     = (rd_lo || rd_hi) ? 2'b00 : 2'b10;
         hi_shadow_d = rd_lo ? mtime_q[63:32] : hi_shadow_q;
      end else if (rvalid && rready) begin
         r_state_d = R_IDLE;
      end
   end

   // A handshake in the current cycle is forwarded so the write lands on that same edge.
   always_comb begin
      aw_hs    = awvalid && !aw_got_q;
      w_hs     = wvalid && !w_got_q;
      wr_addr  = aw_got_q ? awaddr_q : awaddr;
      wr_data  = w_got_q ? wdata_q : wdata;
      wr_strb  = w_got_q ? wstrb_q : wstrb;
      wr_go    = (aw_got_q || aw_hs) && (w_got_q || w_hs) && !bvalid_q;
      wr_lo    = wr_addr == RTC_ADDR;
      wr_hi    = wr_addr == RTC_ADDR_HIGH;
      aw_got_d = aw_got_q || aw_hs;
      w_got_d  = w_got_q || w_hs;
      awaddr_d = aw_hs ? awaddr : awaddr_q;
      wdata_d  = w_hs ? wdata : wdata_q;
      wstrb_d  = w_hs ? wstrb : wstrb_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      if (wr_go) begin
         bvalid_d = 1'b1;
         bresp_d  = (wr_lo || wr_hi) ? 2'b00 : 2'b10;
      end else if (bvalid_q && bready) begin
         bvalid_d = 1'b0;
         aw_got_d = 1'b0;
         w_got_d  = 1'b0;
      end
   end

   // An applied write overrides that cycle's tick and restarts the prescaler.
   always_comb begin
      presc_d = (presc_q == P_LAST) ? '0 : presc_q + PW'(1);
      mtime_d = mtime_q + 64'(presc_q == P_LAST);
      if (wr_go && (wr_lo || wr_hi)) begin
         presc_d = '0;
         mtime_d = mtime_q;
         for (int i = 0; i < 8; i++)
            if (wr_strb[i] && (i < 4 ? wr_lo : wr_hi)) mtime_d[8*i +: 8] = wr_data[8*i +: 8];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state_q   <= R_IDLE;
         rdata_q     <= '0;
         rresp_q     <= '0;
         hi_shadow_q <= '0;
         mtime_q     <= '0;
         presc_q     <= '0;
         aw_got_q    <= 1'b0;
         w_got_q     <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         bvalid_q    <= 1'b0;
         bresp_q     <= '0;
      end else begin
         r_state_q   <= r_state_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         hi_shadow_q <= hi_shadow_d;
         mtime_q     <= mtime_d;
         presc_q     <= presc_d;
         aw_got_q    <= aw_got_d;
         w_got_q     <= w_got_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
      end
   end
endmodule
